// File: rtl/mul_pkg.sv
// Shared arithmetic-unit helpers for the iterative multiplier (and later the divider).
// Functions work on MAX_SIZE-wide values; callers extend/truncate to their own width.
package mul_pkg;

    localparam int unsigned DEFAULT_SIZE = 16;
    localparam int unsigned MAX_SIZE     = 64;

    // Magnitude of a value already extended to MAX_SIZE bits (sign-extended when signed).
    // The most-negative SIZE-bit number yields 2^(SIZE-1) once truncated back.
    function automatic logic [MAX_SIZE-1:0] abs_mag(
        input logic [MAX_SIZE-1:0] value,
        input logic                is_signed
    );
        return (is_signed && value[MAX_SIZE-1]) ? -value : value;
    endfunction

    // Clamp a 2*size-bit product (in the low bits of full_product) into size bits.
    // Returns {ovf, clamped}; only clamped[size-1:0] is meaningful.
    function automatic logic [MAX_SIZE:0] sat_clamp(
        input logic [2*MAX_SIZE-1:0] full_product,
        input logic                  is_signed,
        input int unsigned           size
    );
        logic                ovf;
        logic                top;
        logic [MAX_SIZE-1:0] clamped;
        ovf     = 1'b0;
        top     = 1'b0;
        clamped = '0;
        for (int unsigned i = 0; i < 2 * MAX_SIZE; i++) begin
            if (i == 2 * size - 1) top = full_product[i];
        end
        // Signed fits when bits [2*size-1:size-1] all equal the sign; unsigned when the top half is 0.
        for (int unsigned i = 0; i < 2 * MAX_SIZE; i++) begin
            if (is_signed) begin
                if (i >= size - 1 && i < 2 * size && full_product[i] != top) ovf = 1'b1;
            end else begin
                if (i >= size && i < 2 * size && full_product[i]) ovf = 1'b1;
            end
        end
        for (int unsigned i = 0; i < MAX_SIZE; i++) begin
            if (i < size) begin
                if (!ovf)            clamped[i] = full_product[i];
                else if (!is_signed) clamped[i] = 1'b1;
                else                 clamped[i] = (i == size - 1) ? top : ~top;
            end
        end
        return {ovf, clamped};
    endfunction

endpackage

// File: rtl/seq_multiplier_sat.sv
// Saturation stage: clamps the full product into SIZE bits and flags when clamping occurred.
module seq_multiplier_sat
    import mul_pkg::*;
#(
    parameter int unsigned SIZE = DEFAULT_SIZE
) (
    input  logic [2*SIZE-1:0] product,
    input  logic              is_signed,
    output logic [SIZE-1:0]   product_sat,
    output logic              ovf
);

    logic [MAX_SIZE-1:0] clamped;

    assign {ovf, clamped} = sat_clamp((2 * MAX_SIZE)'(product), is_signed, SIZE);
    assign product_sat    = clamped[SIZE-1:0];

    // Bits above SIZE are always zero from the clamp helper.
    if (SIZE < MAX_SIZE) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^clamped[MAX_SIZE-1:SIZE];
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, SIZE cycles per result.
// Signed operands are handled as magnitudes with a final conditional negate.
// Optional macro SEQ_MULTIPLIER_SAT_EN adds product_sat/ovf saturation outputs.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int unsigned SIZE = DEFAULT_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              is_signed,
    input  logic [SIZE-1:0]   multiplicand,
    input  logic [SIZE-1:0]   multiplier,
    output logic [2*SIZE-1:0] product,
    output logic              done
`ifdef SEQ_MULTIPLIER_SAT_EN
    ,
    output logic [SIZE-1:0]   product_sat,
    output logic              ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(SIZE) + 1;

    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [SIZE-1:0]     mag_a, mag_a_next;
    logic [SIZE-1:0]     mplr, mplr_next;
    logic [SIZE:0]       acc, acc_next;
    logic [SIZE:0]       sum;
    logic                neg, neg_next;
    logic                busy;
    logic [MAX_SIZE-1:0] ext_a, ext_b;
    logic [SIZE-1:0]     load_a, load_b;
    logic [2*SIZE-1:0]   mag_p;
    logic                unused_acc_msb;

    assign busy = (cnt != '0);
    assign done = ~busy;

    // Extend operands to helper width, sign-extending when signed so abs_mag sees the true value.
    always_comb begin
        ext_a = MAX_SIZE'(multiplicand);
        ext_b = MAX_SIZE'(multiplier);
        if (is_signed) begin
            ext_a = MAX_SIZE'($signed(multiplicand));
            ext_b = MAX_SIZE'($signed(multiplier));
        end
    end

    assign load_a = SIZE'(abs_mag(ext_a, is_signed));
    assign load_b = SIZE'(abs_mag(ext_b, is_signed));

    // Next state: shift-add step while busy, operand load on en while idle, otherwise hold.
    always_comb begin
        cnt_next   = cnt;
        mag_a_next = mag_a;
        mplr_next  = mplr;
        acc_next   = acc;
        neg_next   = neg;
        sum        = acc + (mplr[0] ? {1'b0, mag_a} : '0);
        if (busy) begin
            // {acc, mplr} <= {sum, mplr} >> 1
            acc_next  = {1'b0, sum[SIZE:1]};
            mplr_next = {sum[0], mplr[SIZE-1:1]};
            cnt_next  = cnt - CNT_W'(1);
        end else if (en) begin
            mag_a_next = load_a;
            mplr_next  = load_b;
            acc_next   = '0;
            neg_next   = is_signed & (multiplicand[SIZE-1] ^ multiplier[SIZE-1]);
            cnt_next   = CNT_W'(SIZE);
        end
    end

    // State registers, cleared asynchronously so done=1 and product=0 in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            mag_a <= '0;
            mplr  <= '0;
            acc   <= '0;
            neg   <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            mag_a <= mag_a_next;
            mplr  <= mplr_next;
            acc   <= acc_next;
            neg   <= neg_next;
        end
    end

    // acc[SIZE] is always 0 once the run completes.
    assign unused_acc_msb = acc[SIZE];
    assign mag_p          = {acc[SIZE-1:0], mplr};
    assign product        = neg ? -mag_p : mag_p;

`ifdef SEQ_MULTIPLIER_SAT_EN
    logic sgn;

    // Signedness of the current operation, needed to pick the clamp range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn <= 1'b0;
        end else if (!busy && en) begin
            sgn <= is_signed;
        end
    end

    seq_multiplier_sat #(
        .SIZE(SIZE)
    ) u_sat (
        .product    (product),
        .is_signed  (sgn),
        .product_sat(product_sat),
        .ovf        (ovf)
    );
`endif

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (SIZE=16); covers the saturation
// outputs when SEQ_MULTIPLIER_SAT_EN is defined.
module tb_seq_multiplier;

    logic        clk;
    logic        rst;
    logic        en;
    logic        is_signed;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic [31:0] product;
    logic        done;
`ifdef SEQ_MULTIPLIER_SAT_EN
    logic [15:0] product_sat;
    logic        ovf;
`endif

    int n_checks = 0;
    int n_bad    = 0;

    seq_multiplier #(
        .SIZE(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .is_signed   (is_signed),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .product     (product),
        .done        (done)
`ifdef SEQ_MULTIPLIER_SAT_EN
        ,
        .product_sat (product_sat),
        .ovf         (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge while idle: start, then count cycles until done returns.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [31:0] exp);
        int cyc;
        en           = 1'b1;
        multiplicand = a;
        multiplier   = b;
        is_signed    = s;
        @(negedge clk);
        en = 1'b0;
        check({tag, "_busy"}, 64'(done), 64'd0);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_cycles"}, 64'(cyc), 64'd16);
        check({tag, "_product"}, 64'(product), 64'(exp));
    endtask

    initial begin
        int cyc;
        rst          = 1'b1;
        en           = 1'b0;
        is_signed    = 1'b0;
        multiplicand = 16'h0;
        multiplier   = 16'h0;
        #1;
        check("reset_done", 64'(done), 64'd1);
        check("reset_product", 64'(product), 64'd0);
`ifdef SEQ_MULTIPLIER_SAT_EN
        check("reset_sat", 64'(product_sat), 64'd0);
        check("reset_ovf", 64'(ovf), 64'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_done", 64'(done), 64'd1);
        check("post_reset_product", 64'(product), 64'd0);

        run_op("u3x5", 16'd3, 16'd5, 1'b0, 32'h0000_000F);
        run_op("s_m7x6", 16'hFFF9, 16'd6, 1'b1, 32'hFFFF_FFD6);
        run_op("s_min_sq", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        run_op("u_ffff_sq", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        run_op("s_ffff_sq", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);
        run_op("s_zero", 16'h0000, 16'hFFF9, 1'b1, 32'h0000_0000);

        // Busy-time interference: en and operand changes mid-run must be ignored.
        en           = 1'b1;
        multiplicand = 16'd10;
        multiplier   = 16'd10;
        is_signed    = 1'b0;
        @(negedge clk);
        en  = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) begin
                en           = 1'b1;
                multiplicand = 16'd2;
                multiplier   = 16'd2;
                is_signed    = 1'b1;
            end
            if (cyc == 6) en = 1'b0;
        end
        check("interfere_cycles", 64'(cyc), 64'd16);
        check("interfere_product", 64'(product), 64'h64);

        // Idle hold: result persists while en=0 even as operand pins move.
        multiplicand = 16'h1234;
        multiplier   = 16'h5678;
        repeat (3) @(negedge clk);
        check("hold_done", 64'(done), 64'd1);
        check("hold_product", 64'(product), 64'h64);

        // Reset at busy cycle 8 discards the partial result.
        en           = 1'b1;
        multiplicand = 16'h1234;
        multiplier   = 16'h0010;
        is_signed    = 1'b0;
        @(negedge clk);
        en = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_busy", 64'(done), 64'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_done", 64'(done), 64'd1);
        check("mid_rst_product", 64'(product), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("u4x4", 16'd4, 16'd4, 1'b0, 32'h0000_0010);

        // Back-to-back: each run_op starts at the first idle edge after the previous one.
        run_op("b2b_a", 16'd5, 16'd7, 1'b0, 32'h0000_0023);
        run_op("b2b_b", 16'd6, 16'd9, 1'b0, 32'h0000_0036);

`ifdef SEQ_MULTIPLIER_SAT_EN
        run_op("sat_pos", 16'd300, 16'd300, 1'b1, 32'h0001_5F90);
        check("sat_pos_sat", 64'(product_sat), 64'h7FFF);
        check("sat_pos_ovf", 64'(ovf), 64'd1);
        run_op("sat_neg", 16'hFED4, 16'd300, 1'b1, 32'hFFFE_A070);
        check("sat_neg_sat", 64'(product_sat), 64'h8000);
        check("sat_neg_ovf", 64'(ovf), 64'd1);
        run_op("sat_fit", 16'd100, 16'hFFFD, 1'b1, 32'hFFFF_FED4);
        check("sat_fit_sat", 64'(product_sat), 64'hFED4);
        check("sat_fit_ovf", 64'(ovf), 64'd0);
        run_op("sat_uns", 16'h0100, 16'h0100, 1'b0, 32'h0001_0000);
        check("sat_uns_sat", 64'(product_sat), 64'hFFFF);
        check("sat_uns_ovf", 64'(ovf), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
